// File: rtl/usb_bus_state_ctrl.sv
// -----------------------------------------------------------------------------
// usb_bus_state_ctrl
//
// Device-side USB bus-state controller sitting above the UTM. Watches the
// synchronised line state to detect bus reset, suspend and host resume,
// sequences the UTM operating mode and times the device-driven K used for
// remote wakeup. Reset/suspend/resume events go to the protocol engine.
//
// Ports
//   clk             in   1  UTM clock
//   rst             in   1  synchronous reset, active-high
//   dev_en          in   1  device enabled/attached (pull-up on)
//   utm_line_state  in   2  line state (00 SE0, 01 J, 10 K, 11 SE1), synchronised
//   wakeup_req      in   1  1-cycle remote wakeup request (already feature-gated)
//   utm_op_mode     out  2  UTM op mode (00 NORMAL, 01 NONDRIVE, 10 DISABLE)
//   rwake_drive     out  1  datapath holds K on the bus while high
//   bus_reset       out  1  1-cycle pulse per detected bus reset
//   suspend         out  1  level, high while suspended
//   resume          out  1  1-cycle pulse on leaving suspend (host or remote)
//
// All outputs are registered and change the cycle after their condition.
// -----------------------------------------------------------------------------
module usb_bus_state_ctrl #(
    parameter int unsigned RESET_CYC      = 120,
    parameter int unsigned SUSPEND_CYC    = 144000,
    parameter int unsigned RWAKE_IDLE_CYC = 240000,
    parameter int unsigned RWAKE_CYC      = 96000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dev_en,
    input  logic [1:0] utm_line_state,
    input  logic       wakeup_req,
    output logic [1:0] utm_op_mode,
    output logic       rwake_drive,
    output logic       bus_reset,
    output logic       suspend,
    output logic       resume
);

    localparam int unsigned MAX_A   = (RESET_CYC > SUSPEND_CYC) ? RESET_CYC : SUSPEND_CYC;
    localparam int unsigned MAX_B   = (RWAKE_IDLE_CYC > RWAKE_CYC) ? RWAKE_IDLE_CYC : RWAKE_CYC;
    localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] RESET_LIM  = CW'(RESET_CYC);
    localparam logic [CW-1:0] SUSP_LIM   = CW'(SUSPEND_CYC);
    localparam logic [CW-1:0] IDLE_LIM   = CW'(RWAKE_IDLE_CYC);
    localparam logic [CW-1:0] RWAKE_LAST = CW'(RWAKE_CYC - 1);

    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_J   = 2'b01;
    localparam logic [1:0] LS_K   = 2'b10;

    localparam logic [1:0] OM_NORMAL   = 2'b00;
    localparam logic [1:0] OM_NONDRIVE = 2'b01;
    localparam logic [1:0] OM_DISABLE  = 2'b10;

    typedef enum logic [2:0] {
        StDetached,
        StActive,
        StSuspended,
        StRwake,
        StResuming
    } state_e;

    state_e        state_q;
    logic [1:0]    line_q;   // line state seen on the previous cycle
    logic [CW-1:0] cnt_q;    // run length of the line state (saturates at SUSP_LIM)
    logic [CW-1:0] tmr_q;    // suspend / remote-wakeup duration timer
    logic          pend_q;   // remote wakeup requested before it was allowed

    logic          line_chg;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] run_len;
    logic [CW-1:0] tmr_inc;
    logic          se0_reset;
    logic          j_idle;

    // run_len is the length of the current run including this cycle's sample.
    // Because it saturates above RESET_LIM, the SE0 match fires once per episode.
    assign line_chg  = (utm_line_state != line_q);
    assign cnt_inc   = (cnt_q >= SUSP_LIM) ? SUSP_LIM : cnt_q + CW'(1);
    assign run_len   = line_chg ? CW'(1) : cnt_inc;
    assign tmr_inc   = (tmr_q == {CW{1'b1}}) ? tmr_q : tmr_q + CW'(1);
    assign se0_reset = (utm_line_state == LS_SE0) && (run_len == RESET_LIM);
    assign j_idle    = (utm_line_state == LS_J) && (run_len == SUSP_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StDetached;
            line_q      <= LS_SE0;
            cnt_q       <= '0;
            tmr_q       <= '0;
            pend_q      <= 1'b0;
            utm_op_mode <= OM_NONDRIVE;
            rwake_drive <= 1'b0;
            bus_reset   <= 1'b0;
            suspend     <= 1'b0;
            resume      <= 1'b0;
        end else begin
            bus_reset <= 1'b0;
            resume    <= 1'b0;
            line_q    <= utm_line_state;
            cnt_q     <= run_len;

            if (!dev_en) begin
                state_q     <= StDetached;
                cnt_q       <= '0;
                tmr_q       <= '0;
                pend_q      <= 1'b0;
                utm_op_mode <= OM_NONDRIVE;
                rwake_drive <= 1'b0;
                suspend     <= 1'b0;
            end else begin
                unique case (state_q)
                    StDetached: begin
                        // Count line activity only from the first attached cycle.
                        state_q     <= StActive;
                        utm_op_mode <= OM_NORMAL;
                        cnt_q       <= '0;
                    end

                    StActive: begin
                        if (se0_reset) begin
                            bus_reset <= 1'b1;
                        end else if (j_idle) begin
                            state_q <= StSuspended;
                            suspend <= 1'b1;
                            tmr_q   <= '0;
                            pend_q  <= 1'b0;
                        end
                    end

                    StSuspended: begin
                        tmr_q <= tmr_inc;
                        if (utm_line_state == LS_K) begin
                            state_q <= StResuming;
                            suspend <= 1'b0;
                            resume  <= 1'b1;
                            pend_q  <= 1'b0;
                        end else if (se0_reset) begin
                            state_q   <= StActive;
                            suspend   <= 1'b0;
                            bus_reset <= 1'b1;
                            pend_q    <= 1'b0;
                        end else if ((wakeup_req || pend_q) && (tmr_q >= IDLE_LIM)) begin
                            state_q     <= StRwake;
                            utm_op_mode <= OM_DISABLE;
                            rwake_drive <= 1'b1;
                            suspend     <= 1'b0;
                            resume      <= 1'b1;
                            tmr_q       <= '0;
                        end else if (wakeup_req) begin
                            pend_q <= 1'b1;
                        end
                    end

                    StRwake: begin
                        // We are driving K ourselves; the line tells us nothing.
                        tmr_q <= tmr_inc;
                        cnt_q <= '0;
                        if (tmr_q == RWAKE_LAST) begin
                            state_q     <= StResuming;
                            utm_op_mode <= OM_NORMAL;
                            rwake_drive <= 1'b0;
                            pend_q      <= 1'b0;
                        end
                    end

                    StResuming: begin
                        // Host ends resume with an EOP (SE0 then J).
                        if ((utm_line_state == LS_SE0) || (utm_line_state == LS_J)) begin
                            state_q <= StActive;
                            cnt_q   <= '0;
                            tmr_q   <= '0;
                        end
                    end

                    default: begin
                        state_q     <= StDetached;
                        utm_op_mode <= OM_NONDRIVE;
                        rwake_drive <= 1'b0;
                        suspend     <= 1'b0;
                        pend_q      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_bus_state_ctrl.sv
// -----------------------------------------------------------------------------
// tb_usb_bus_state_ctrl
//
// Directed bench for usb_bus_state_ctrl with short timing parameters
// (RESET_CYC=8, SUSPEND_CYC=32, RWAKE_IDLE_CYC=16, RWAKE_CYC=10). Each step
// drives inputs, takes one clock and compares all outputs 1ns after the edge.
// -----------------------------------------------------------------------------
module tb_usb_bus_state_ctrl;

    localparam logic [1:0] SE0 = 2'b00;
    localparam logic [1:0] J   = 2'b01;
    localparam logic [1:0] K   = 2'b10;
    localparam logic [1:0] NRM = 2'b00;
    localparam logic [1:0] NDR = 2'b01;
    localparam logic [1:0] DIS = 2'b10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dev_en = 1'b0;
    logic [1:0] utm_line_state = J;
    logic       wakeup_req = 1'b0;
    logic [1:0] utm_op_mode;
    logic       rwake_drive;
    logic       bus_reset;
    logic       suspend;
    logic       resume;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    usb_bus_state_ctrl #(
        .RESET_CYC      (8),
        .SUSPEND_CYC    (32),
        .RWAKE_IDLE_CYC (16),
        .RWAKE_CYC      (10)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .dev_en         (dev_en),
        .utm_line_state (utm_line_state),
        .wakeup_req     (wakeup_req),
        .utm_op_mode    (utm_op_mode),
        .rwake_drive    (rwake_drive),
        .bus_reset      (bus_reset),
        .suspend        (suspend),
        .resume         (resume)
    );

    typedef struct {
        logic       r;
        logic       e;
        logic [1:0] l;
        logic       w;
        logic [1:0] op;
        logic       rd;
        logic       br;
        logic       su;
        logic       re;
        string      nm;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input int n, input logic r, input logic e, input logic [1:0] l,
                                input logic w, input logic [1:0] op, input logic rd,
                                input logic br, input logic su, input logic re, input string nm);
        vec_t v;
        v.r = r; v.e = e; v.l = l; v.w = w;
        v.op = op; v.rd = rd; v.br = br; v.su = su; v.re = re; v.nm = nm;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endfunction

    // One clock with the given inputs, then compare every output.
    task automatic cyc(input logic r, input logic e, input logic [1:0] l, input logic w,
                       input logic [1:0] op, input logic rd, input logic br, input logic su,
                       input logic re, input string nm);
        logic [5:0] got;
        logic [5:0] exp;
        rst = r; dev_en = e; utm_line_state = l; wakeup_req = w;
        @(posedge clk);
        #1;
        got = {utm_op_mode, rwake_drive, bus_reset, suspend, resume};
        exp = {op, rd, br, su, re};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got {op,rd,br,su,re}=%b required %b", nm, $time, got, exp);
        end
    endtask

    task automatic run(input int n, input logic r, input logic e, input logic [1:0] l,
                       input logic w, input logic [1:0] op, input logic rd, input logic br,
                       input logic su, input logic re, input string nm);
        for (int i = 0; i < n; i++) cyc(r, e, l, w, op, rd, br, su, re, nm);
    endtask

    initial begin
        // Reset, attach, SE0 glitch / bus reset, suspend entry with a late K.
        add(1,  1, 0, J,   0, NDR, 0, 0, 0, 0, "reset");
        add(1,  1, 1, J,   0, NDR, 0, 0, 0, 0, "reset_over_en");
        add(1,  0, 0, J,   0, NDR, 0, 0, 0, 0, "detached");
        add(1,  0, 1, J,   0, NRM, 0, 0, 0, 0, "attach");
        add(7,  0, 1, SE0, 0, NRM, 0, 0, 0, 0, "se0_glitch");
        add(1,  0, 1, J,   1, NRM, 0, 0, 0, 0, "wreq_active_ignored");
        add(7,  0, 1, SE0, 0, NRM, 0, 0, 0, 0, "se0_pre");
        add(1,  0, 1, SE0, 0, NRM, 0, 1, 0, 0, "bus_reset");
        add(12, 0, 1, SE0, 0, NRM, 0, 0, 0, 0, "se0_held");
        add(30, 0, 1, J,   0, NRM, 0, 0, 0, 0, "j_idle");
        add(1,  0, 1, K,   0, NRM, 0, 0, 0, 0, "k_at_31");
        add(31, 0, 1, J,   0, NRM, 0, 0, 0, 0, "j_restart");
        add(1,  0, 1, J,   0, NRM, 0, 0, 1, 0, "suspend");

        foreach (tbl[i])
            cyc(tbl[i].r, tbl[i].e, tbl[i].l, tbl[i].w,
                tbl[i].op, tbl[i].rd, tbl[i].br, tbl[i].su, tbl[i].re, tbl[i].nm);

        // Host resume, EOP back to active, suspend again.
        run(3,  0, 1, J,   0, NRM, 0, 0, 1, 0, "susp_idle");
        cyc(    0, 1, K,   0, NRM, 0, 0, 0, 1, "host_resume");
        cyc(    0, 1, K,   0, NRM, 0, 0, 0, 0, "resuming_k");
        cyc(    0, 1, K,   1, NRM, 0, 0, 0, 0, "resuming_wreq_ignored");
        cyc(    0, 1, SE0, 0, NRM, 0, 0, 0, 0, "eop_se0");
        run(31, 0, 1, J,   0, NRM, 0, 0, 0, 0, "reidle");
        cyc(    0, 1, J,   0, NRM, 0, 0, 1, 0, "resuspend");

        // Early wakeup request is held until the idle timer reaches 16.
        run(4,  0, 1, J,   0, NRM, 0, 0, 1, 0, "rw_wait");
        cyc(    0, 1, J,   1, NRM, 0, 0, 1, 0, "rw_req_early");
        run(11, 0, 1, J,   0, NRM, 0, 0, 1, 0, "rw_pending");
        cyc(    0, 1, J,   0, DIS, 1, 0, 0, 1, "rw_enter");
        run(9,  0, 1, SE0, 0, DIS, 1, 0, 0, 0, "rw_drive");
        cyc(    0, 1, SE0, 0, NRM, 0, 0, 0, 0, "rw_done");
        cyc(    0, 1, SE0, 0, NRM, 0, 0, 0, 0, "rw_eop");
        cyc(    0, 1, J,   0, NRM, 0, 0, 0, 0, "active_after_rw");
        run(30, 0, 1, J,   0, NRM, 0, 0, 0, 0, "idle2");
        cyc(    0, 1, J,   0, NRM, 0, 0, 1, 0, "suspend2");

        // Pending flag must be gone; direct request, then detach mid-wakeup.
        run(20, 0, 1, J,   0, NRM, 0, 0, 1, 0, "no_stale_pend");
        cyc(    0, 1, J,   1, DIS, 1, 0, 0, 1, "rw_direct");
        run(3,  0, 1, K,   0, DIS, 1, 0, 0, 0, "rw_drive2");
        cyc(    0, 0, K,   0, NDR, 0, 0, 0, 0, "en_drop");
        cyc(    0, 1, J,   0, NRM, 0, 0, 0, 0, "reattach");

        // Reset while suspended.
        run(31, 0, 1, J,   0, NRM, 0, 0, 0, 0, "idle3");
        cyc(    0, 1, J,   0, NRM, 0, 0, 1, 0, "suspend3");
        run(2,  0, 1, J,   0, NRM, 0, 0, 1, 0, "susp3_idle");
        cyc(    1, 1, J,   0, NDR, 0, 0, 0, 0, "rst_susp");
        cyc(    0, 1, J,   0, NRM, 0, 0, 0, 0, "attach2");

        // Bus reset while suspended: no resume pulse.
        run(31, 0, 1, J,   0, NRM, 0, 0, 0, 0, "idle4");
        cyc(    0, 1, J,   0, NRM, 0, 0, 1, 0, "suspend4");
        run(7,  0, 1, SE0, 0, NRM, 0, 0, 1, 0, "susp_se0");
        cyc(    0, 1, SE0, 0, NRM, 0, 1, 0, 0, "susp_bus_reset");
        cyc(    0, 1, SE0, 0, NRM, 0, 0, 0, 0, "se0_no_repulse");
        cyc(    0, 1, J,   0, NRM, 0, 0, 0, 0, "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
